multicycle_control: RTL and testbench
=====================================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter MEM_HANDSHAKE, default 1, meaning: 1 = memory states wait on mem_ready; 0 = mem_ready is ignored and treated as 1.
REQ-002 The block SHALL have one clock; reset is synchronous and active-high.
REQ-003 clock  in  1  system clock; all state updates occur on the rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 Op  in  6  instruction opcode, taken from the instruction register.
REQ-006 mem_ready  in  1  memory completes the current read/write this cycle.
REQ-007 PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite, ALUSrcA, RegWrite, RegDst  out  1 each  datapath controls.
REQ-008 ALUOp  out  2  goes to the ALU control stage (00 add, 01 subtract, 10 decode funct).
REQ-009 ALUSrcB  out  2  B-operand select (00 reg B, 01 constant 4, 10 sign-extended imm, 11 imm<<2).
REQ-010 PCSource  out  2  PC select (00 ALU result, 01 ALUOut, 10 jump target).
REQ-011 state  out  4  current state encoding, for debug.
REQ-012 instr_done  out  1  one-cycle pulse on the last cycle of each instruction.
REQ-013 illegal_op  out  1  one-cycle pulse in DECODE when Op is unsupported.

Function
REQ-014 Moore FSM; state encodings: FETCH=0, DECODE=1, MEMADDR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RCOMP=7, BRANCH=8, JUMP=9.
REQ-015 Encodings 10-15 SHALL transition to FETCH on the next edge, with all outputs 0 while in those states.
REQ-016 Any output not listed for a state SHALL be 0 in that state.
REQ-017 FETCH SHALL drive MemRead=1, ALUSrcB=01, ALUOp=00.
REQ-018 In FETCH, IRWrite=1 and PCWrite=1 only in the cycle mem_ready=1; that cycle the FSM moves to DECODE, otherwise it holds in FETCH.
REQ-019 DECODE SHALL drive ALUSrcB=11, ALUOp=00.
REQ-020 DECODE transitions: Op 35 or 43 -> MEMADDR; Op 0 -> EXEC; Op 4 -> BRANCH; Op 2 -> JUMP; any other Op -> FETCH with illegal_op=1 and instr_done=1.
REQ-021 MEMADDR SHALL drive ALUSrcA=1, ALUSrcB=10, ALUOp=00, then go to MEMRD if Op=35, else to MEMWR.
REQ-022 MEMRD SHALL drive MemRead=1, IorD=1, and hold until mem_ready, then go to MEMWB.
REQ-023 MEMWB SHALL drive RegWrite=1, MemtoReg=1, RegDst=0, instr_done=1, then go to FETCH.
REQ-024 MEMWR SHALL drive MemWrite=1, IorD=1, and hold until mem_ready; in the mem_ready cycle instr_done=1, then go to FETCH.
REQ-025 MemWrite SHALL remain asserted for every cycle of the wait in MEMWR.
REQ-026 EXEC SHALL drive ALUSrcA=1, ALUSrcB=00, ALUOp=10, then go to RCOMP.
REQ-027 RCOMP SHALL drive RegWrite=1, RegDst=1, MemtoReg=0, instr_done=1, then go to FETCH.
REQ-028 BRANCH SHALL drive ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01, instr_done=1, then go to FETCH.
REQ-029 JUMP SHALL drive PCWrite=1, PCSource=10, instr_done=1, then go to FETCH.
REQ-030 Op SHALL be sampled only in DECODE and MEMADDR; Op changes in other states have no effect.
REQ-031 Cycle counts with mem_ready held at 1: R-type 4, lw 5, sw 4, beq 3, j 3.
REQ-032 Each memory wait cycle SHALL add exactly one cycle to these counts.

Reset
REQ-033 While reset=1, all outputs SHALL be 0 (including IRWrite, PCWrite, MemRead), and state SHALL load FETCH on the edge.
REQ-034 Reset asserted in any state, including mid-wait in MEMRD or MEMWR, SHALL abort the instruction with no further write-enable pulses.
REQ-035 reset SHALL take priority over mem_ready and Op.
REQ-036 The first cycle after reset deasserts SHALL be FETCH with MemRead=1.

Verification
REQ-037 Op=0, mem_ready=1 -> state sequence 0,1,6,7,0; ALUOp=10 in EXEC; RegWrite=1, RegDst=1 in RCOMP; one instr_done pulse.
REQ-038 Op=35 with mem_ready low for 3 cycles in MEMRD -> MemRead and IorD stay at 1 for 4 cycles; MEMWB asserts RegWrite and MemtoReg; total 8 cycles.
REQ-039 Op=4 -> BRANCH asserts ALUOp=01, PCWriteCond=1, PCSource=01; Op=2 -> JUMP asserts PCWrite=1, PCSource=10; each takes 3 cycles.
REQ-040 Op=63 -> illegal_op and instr_done pulse once in DECODE, next state FETCH, no RegWrite/MemWrite/PCWrite beyond FETCH.
REQ-041 reset pulsed during a MEMWR wait -> all outputs 0 in the reset cycle, next state FETCH, and MemWrite never asserts again for that instruction.
REQ-042 MEM_HANDSHAKE=0 with mem_ready tied 0 -> lw completes in 5 cycles.

Source files
------------

// File: rtl/multicycle_control.sv
// Multicycle MIPS-style datapath controller: Moore FSM sequencing fetch, decode,
// memory, R-type, branch and jump steps, with optional memory-ready handshake.
module multicycle_control #(
  parameter bit MEM_HANDSHAKE = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] Op,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       MemtoReg,
  output logic       IRWrite,
  output logic       ALUSrcA,
  output logic       RegWrite,
  output logic       RegDst,
  output logic [1:0] ALUOp,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSource,
  output logic [3:0] state,
  output logic       instr_done,
  output logic       illegal_op
);

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADDR = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXEC    = 4'd6,
    S_RCOMP   = 4'd7,
    S_BRANCH  = 4'd8,
    S_JUMP    = 4'd9
  } state_t;

  state_t r_state;
  state_t w_next;
  logic   w_ready;

  // Without the handshake every memory access is assumed to finish in one cycle.
  assign w_ready = MEM_HANDSHAKE ? mem_ready : 1'b1;

  always_ff @(posedge clock) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:   w_next = w_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (Op)
          OP_LW, OP_SW: w_next = S_MEMADDR;
          OP_RTYPE:     w_next = S_EXEC;
          OP_BEQ:       w_next = S_BRANCH;
          OP_J:         w_next = S_JUMP;
          default:      w_next = S_FETCH;
        endcase
      end
      S_MEMADDR: w_next = (Op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   w_next = w_ready ? S_MEMWB : S_MEMRD;
      S_MEMWB:   w_next = S_FETCH;
      S_MEMWR:   w_next = w_ready ? S_FETCH : S_MEMWR;
      S_EXEC:    w_next = S_RCOMP;
      S_RCOMP:   w_next = S_FETCH;
      S_BRANCH:  w_next = S_FETCH;
      S_JUMP:    w_next = S_FETCH;
      default:   w_next = S_FETCH;
    endcase
  end

  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    MemtoReg    = 1'b0;
    IRWrite     = 1'b0;
    ALUSrcA     = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    ALUOp       = 2'b00;
    ALUSrcB     = 2'b00;
    PCSource    = 2'b00;
    instr_done  = 1'b0;
    illegal_op  = 1'b0;
    // Reset gates every output so no write enable can leak during the reset cycle.
    if (!reset) begin
      case (r_state)
        S_FETCH: begin
          MemRead = 1'b1;
          ALUSrcB = 2'b01;
          IRWrite = w_ready;
          PCWrite = w_ready;
        end
        S_DECODE: begin
          ALUSrcB = 2'b11;
          if (!(Op == OP_LW || Op == OP_SW || Op == OP_RTYPE ||
                Op == OP_BEQ || Op == OP_J)) begin
            illegal_op = 1'b1;
            instr_done = 1'b1;
          end
        end
        S_MEMADDR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
        end
        S_MEMRD: begin
          MemRead = 1'b1;
          IorD    = 1'b1;
        end
        S_MEMWB: begin
          RegWrite   = 1'b1;
          MemtoReg   = 1'b1;
          instr_done = 1'b1;
        end
        S_MEMWR: begin
          MemWrite   = 1'b1;
          IorD       = 1'b1;
          instr_done = w_ready;
        end
        S_EXEC: begin
          ALUSrcA = 1'b1;
          ALUOp   = 2'b10;
        end
        S_RCOMP: begin
          RegWrite   = 1'b1;
          RegDst     = 1'b1;
          instr_done = 1'b1;
        end
        S_BRANCH: begin
          ALUSrcA     = 1'b1;
          ALUOp       = 2'b01;
          PCWriteCond = 1'b1;
          PCSource    = 2'b01;
          instr_done  = 1'b1;
        end
        S_JUMP: begin
          PCWrite    = 1'b1;
          PCSource   = 2'b10;
          instr_done = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign state = reset ? 4'd0 : r_state;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: the driver queues a hand-built
// expected control vector per cycle, a monitor pops and compares at negedge.
module tb_multicycle_control;

  logic       clk;
  logic       reset;
  logic [5:0] Op;
  logic       mem_ready;

  logic       a_pcw, a_pcwc, a_iord, a_mr, a_mw, a_m2r, a_irw, a_asa, a_rw, a_rd, a_done, a_ill;
  logic [1:0] a_aluop, a_asb, a_pcs;
  logic [3:0] a_state;
  logic       b_pcw, b_pcwc, b_iord, b_mr, b_mw, b_m2r, b_irw, b_asa, b_rw, b_rd, b_done, b_ill;
  logic [1:0] b_aluop, b_asb, b_pcs;
  logic [3:0] b_state;

  multicycle_control #(.MEM_HANDSHAKE(1'b1)) u_dut_hs (
    .clock(clk), .reset(reset), .Op(Op), .mem_ready(mem_ready),
    .PCWrite(a_pcw), .PCWriteCond(a_pcwc), .IorD(a_iord), .MemRead(a_mr),
    .MemWrite(a_mw), .MemtoReg(a_m2r), .IRWrite(a_irw), .ALUSrcA(a_asa),
    .RegWrite(a_rw), .RegDst(a_rd), .ALUOp(a_aluop), .ALUSrcB(a_asb),
    .PCSource(a_pcs), .state(a_state), .instr_done(a_done), .illegal_op(a_ill)
  );

  multicycle_control #(.MEM_HANDSHAKE(1'b0)) u_dut_nohs (
    .clock(clk), .reset(reset), .Op(Op), .mem_ready(1'b0),
    .PCWrite(b_pcw), .PCWriteCond(b_pcwc), .IorD(b_iord), .MemRead(b_mr),
    .MemWrite(b_mw), .MemtoReg(b_m2r), .IRWrite(b_irw), .ALUSrcA(b_asa),
    .RegWrite(b_rw), .RegDst(b_rd), .ALUOp(b_aluop), .ALUSrcB(b_asb),
    .PCSource(b_pcs), .state(b_state), .instr_done(b_done), .illegal_op(b_ill)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {state, PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
  //  ALUSrcA, RegWrite, RegDst, ALUOp, ALUSrcB, PCSource, instr_done, illegal_op}
  typedef logic [21:0] vec_t;
  typedef struct {
    bit     sel;
    vec_t   exp;
    string  name;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t v(input logic [3:0] st,
                             input logic pcw, pcwc, iord, mr, mw, m2r, irw, asa, rw, rd,
                             input logic [1:0] aluop, asb, pcs,
                             input logic done, ill);
    return {st, pcw, pcwc, iord, mr, mw, m2r, irw, asa, rw, rd, aluop, asb, pcs, done, ill};
  endfunction

  vec_t ZERO, FETCH_WAIT, FETCH_GO, DECODE_V, DECODE_ILL, MEMADDR_V, MEMRD_V, MEMWB_V;
  vec_t MEMWR_WAIT, MEMWR_GO, EXEC_V, RCOMP_V, BRANCH_V, JUMP_V;

  wire vec_t w_act_hs = {a_state, a_pcw, a_pcwc, a_iord, a_mr, a_mw, a_m2r, a_irw, a_asa,
                         a_rw, a_rd, a_aluop, a_asb, a_pcs, a_done, a_ill};
  wire vec_t w_act_nohs = {b_state, b_pcw, b_pcwc, b_iord, b_mr, b_mw, b_m2r, b_irw, b_asa,
                           b_rw, b_rd, b_aluop, b_asb, b_pcs, b_done, b_ill};

  // Drive one cycle of inputs and queue the response expected in that cycle.
  task automatic step(input logic rst, input logic [5:0] op, input logic rdy,
                      input vec_t exp, input bit sel, input string name);
    exp_t e;
    reset     = rst;
    Op        = op;
    mem_ready = rdy;
    e.sel  = sel;
    e.exp  = exp;
    e.name = name;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin : monitor
    exp_t e;
    vec_t act;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e   = q.pop_front();
        act = e.sel ? w_act_nohs : w_act_hs;
        checks++;
        if (act !== e.exp) begin
          errors++;
          $display("FAIL %s: got %h (state %0d) expected %h (state %0d)",
                   e.name, act, act[21:18], e.exp, e.exp[21:18]);
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin : stim
    ZERO       = '0;
    FETCH_WAIT = v(4'd0, 0,0,0,1,0,0,0,0,0,0, 2'b00, 2'b01, 2'b00, 0,0);
    FETCH_GO   = v(4'd0, 1,0,0,1,0,0,1,0,0,0, 2'b00, 2'b01, 2'b00, 0,0);
    DECODE_V   = v(4'd1, 0,0,0,0,0,0,0,0,0,0, 2'b00, 2'b11, 2'b00, 0,0);
    DECODE_ILL = v(4'd1, 0,0,0,0,0,0,0,0,0,0, 2'b00, 2'b11, 2'b00, 1,1);
    MEMADDR_V  = v(4'd2, 0,0,0,0,0,0,0,1,0,0, 2'b00, 2'b10, 2'b00, 0,0);
    MEMRD_V    = v(4'd3, 0,0,1,1,0,0,0,0,0,0, 2'b00, 2'b00, 2'b00, 0,0);
    MEMWB_V    = v(4'd4, 0,0,0,0,0,1,0,0,1,0, 2'b00, 2'b00, 2'b00, 1,0);
    MEMWR_WAIT = v(4'd5, 0,0,1,0,1,0,0,0,0,0, 2'b00, 2'b00, 2'b00, 0,0);
    MEMWR_GO   = v(4'd5, 0,0,1,0,1,0,0,0,0,0, 2'b00, 2'b00, 2'b00, 1,0);
    EXEC_V     = v(4'd6, 0,0,0,0,0,0,0,1,0,0, 2'b10, 2'b00, 2'b00, 0,0);
    RCOMP_V    = v(4'd7, 0,0,0,0,0,0,0,0,1,1, 2'b00, 2'b00, 2'b00, 1,0);
    BRANCH_V   = v(4'd8, 0,1,0,0,0,0,0,1,0,0, 2'b01, 2'b00, 2'b01, 1,0);
    JUMP_V     = v(4'd9, 1,0,0,0,0,0,0,0,0,0, 2'b00, 2'b00, 2'b10, 1,0);

    reset = 1'b1; Op = 6'd0; mem_ready = 1'b1;
    @(posedge clk);
    #1;

    // Reset held with ready high: everything must stay quiet.
    step(1, 6'd35, 1, ZERO, 0, "reset0");
    step(1, 6'd0,  1, ZERO, 0, "reset1");

    // R-type, 4 cycles
    step(0, 6'd0, 1, FETCH_GO, 0, "r_fetch");
    step(0, 6'd0, 1, DECODE_V, 0, "r_decode");
    step(0, 6'd9, 1, EXEC_V,   0, "r_exec");
    step(0, 6'd9, 1, RCOMP_V,  0, "r_rcomp");

    // lw with 3 wait cycles in MEMRD, 8 cycles; Op changes in MEMRD ignored
    step(0, 6'd35, 1, FETCH_GO,  0, "lw_fetch");
    step(0, 6'd35, 1, DECODE_V,  0, "lw_decode");
    step(0, 6'd35, 1, MEMADDR_V, 0, "lw_memaddr");
    step(0, 6'd0,  0, MEMRD_V,   0, "lw_memrd_w1");
    step(0, 6'd43, 0, MEMRD_V,   0, "lw_memrd_w2");
    step(0, 6'd4,  0, MEMRD_V,   0, "lw_memrd_w3");
    step(0, 6'd2,  1, MEMRD_V,   0, "lw_memrd_go");
    step(0, 6'd0,  1, MEMWB_V,   0, "lw_memwb");

    // sw with a fetch wait and a write wait
    step(0, 6'd43, 0, FETCH_WAIT, 0, "sw_fetch_wait");
    step(0, 6'd43, 1, FETCH_GO,   0, "sw_fetch");
    step(0, 6'd43, 1, DECODE_V,   0, "sw_decode");
    step(0, 6'd43, 1, MEMADDR_V,  0, "sw_memaddr");
    step(0, 6'd35, 0, MEMWR_WAIT, 0, "sw_memwr_wait");
    step(0, 6'd35, 1, MEMWR_GO,   0, "sw_memwr_go");

    // beq and j, 3 cycles each
    step(0, 6'd4, 1, FETCH_GO, 0, "beq_fetch");
    step(0, 6'd4, 1, DECODE_V, 0, "beq_decode");
    step(0, 6'd0, 1, BRANCH_V, 0, "beq_branch");
    step(0, 6'd2, 1, FETCH_GO, 0, "j_fetch");
    step(0, 6'd2, 1, DECODE_V, 0, "j_decode");
    step(0, 6'd0, 1, JUMP_V,   0, "j_jump");

    // Illegal opcode returns straight to FETCH
    step(0, 6'd63, 1, FETCH_GO,   0, "ill_fetch");
    step(0, 6'd63, 1, DECODE_ILL, 0, "ill_decode");
    step(0, 6'd63, 0, FETCH_WAIT, 0, "ill_back_fetch");
    step(0, 6'd1,  1, FETCH_GO,   0, "ill1_fetch");
    step(0, 6'd1,  1, DECODE_ILL, 0, "ill1_decode");

    // Reset during a MEMWR wait aborts the store
    step(0, 6'd43, 1, FETCH_GO,   0, "rst_fetch");
    step(0, 6'd43, 1, DECODE_V,   0, "rst_decode");
    step(0, 6'd43, 1, MEMADDR_V,  0, "rst_memaddr");
    step(0, 6'd43, 0, MEMWR_WAIT, 0, "rst_memwr_wait");
    step(1, 6'd43, 1, ZERO,       0, "rst_in_memwr");
    step(0, 6'd43, 0, FETCH_WAIT, 0, "rst_after_fetch");
    step(0, 6'd43, 0, FETCH_WAIT, 0, "rst_after_fetch2");

    // No-handshake instance: lw completes in 5 cycles with mem_ready tied low
    step(1, 6'd35, 0, ZERO,      1, "nohs_reset");
    step(0, 6'd35, 0, FETCH_GO,  1, "nohs_fetch");
    step(0, 6'd35, 0, DECODE_V,  1, "nohs_decode");
    step(0, 6'd35, 0, MEMADDR_V, 1, "nohs_memaddr");
    step(0, 6'd35, 0, MEMRD_V,   1, "nohs_memrd");
    step(0, 6'd35, 0, MEMWB_V,   1, "nohs_memwb");
    step(0, 6'd35, 0, FETCH_GO,  1, "nohs_next_fetch");

    @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
